// File: rtl/spart_driver.sv
// Host-side driver for a SPART: programs the baud divisor, then echoes every received
// character back to the transmitter. It reprograms whenever the baud select changes.
module spart_driver #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_char
);

  localparam logic [15:0] Div4800  = 16'(CLK_HZ / (16 * 4800) - 1);
  localparam logic [15:0] Div9600  = 16'(CLK_HZ / (16 * 9600) - 1);
  localparam logic [15:0] Div19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] Div38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  typedef enum logic [2:0] {
    StProgLo,
    StProgHi,
    StIdle,
    StRdRx,
    StWaitTbr,
    StWrTx
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cfg_meta_q, cfg_sync_q;
  logic [1:0]  cfg_q, cfg_d;
  logic [1:0]  prog_cfg_q, prog_cfg_d;
  logic [7:0]  last_char_q, last_char_d;
  logic [1:0]  init_q, init_d;
  logic [15:0] div;
  logic [7:0]  data_out;

  function automatic logic [15:0] divisor(input logic [1:0] cfg);
    logic [15:0] d;
    unique case (cfg)
      2'b00:   d = Div4800;
      2'b01:   d = Div9600;
      2'b10:   d = Div19200;
      default: d = Div38400;
    endcase
    return d;
  endfunction

  // Holds off PROG_LO until the br_cfg synchronizer has seen two clocks.
  assign init_d = {init_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StProgLo;
      cfg_meta_q  <= 2'b00;
      cfg_sync_q  <= 2'b00;
      cfg_q       <= 2'b00;
      prog_cfg_q  <= 2'b00;
      last_char_q <= 8'h00;
      init_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cfg_meta_q  <= br_cfg;
      cfg_sync_q  <= cfg_meta_q;
      cfg_q       <= cfg_d;
      prog_cfg_q  <= prog_cfg_d;
      last_char_q <= last_char_d;
      init_q      <= init_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    prog_cfg_d  = prog_cfg_q;
    last_char_d = last_char_q;
    div         = 16'h0000;
    data_out    = 8'h00;
    iocs        = 1'b0;
    iorw        = 1'b1;
    ioaddr      = 2'b01;

    unique case (state_q)
      StProgLo: begin
        if (init_q[1]) begin
          div        = divisor(cfg_sync_q);
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = 2'b10;
          data_out   = div[7:0];
          prog_cfg_d = cfg_sync_q;
          state_d    = StProgHi;
        end
      end
      StProgHi: begin
        // High byte comes from the value captured with the low byte, so a mid-write
        // br_cfg change cannot split the divisor.
        div      = divisor(prog_cfg_q);
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'b11;
        data_out = div[15:8];
        cfg_d    = prog_cfg_q;
        state_d  = StIdle;
      end
      StIdle: begin
        if (cfg_sync_q != cfg_q) begin
          state_d = StProgLo;
        end else if (rda) begin
          state_d = StRdRx;
        end
      end
      StRdRx: begin
        iocs        = 1'b1;
        ioaddr      = 2'b00;
        last_char_d = databus;
        state_d     = StWaitTbr;
      end
      StWaitTbr: begin
        if (tbr) begin
          state_d = StWrTx;
        end
      end
      StWrTx: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'b00;
        data_out = last_char_q;
        state_d  = StIdle;
      end
      default: state_d = StProgLo;
    endcase
  end

  assign databus   = (iocs && !iorw) ? data_out : 8'hzz;
  assign last_char = last_char_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a bus-level SPART model supplies received bytes and
// logs every write the driver makes.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic [7:0] rx_data;
  wire        iocs;
  wire        iorw;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;
  wire  [7:0] last_char;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int x_err = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         c;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } prog_vec_t;

  spart_driver #(.CLK_HZ(50000000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .br_cfg    (br_cfg),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .last_char (last_char)
  );

  // SPART side: drives rx data on reads; a weak pull makes an undriven bus read 0xFF.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_data : 8'hzz;
  assign (weak0, weak1) databus = 8'hFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && iocs && !iorw) begin
      if ($isunknown(databus)) x_err <= x_err + 1;
      wr_q.push_back('{ioaddr, databus, cyc});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_wr(input int n, input string name);
    int k = 0;
    while (wr_q.size() < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 32'(wr_q.size() >= n), 32'd1);
  endtask

  // Presents one received byte; returns the cycle rda rose and the cycle of the read.
  task automatic send(input logic [7:0] d, output int nc, output int rc);
    int k = 0;
    @(posedge clk);
    #1;
    rx_data = d;
    rda     = 1'b1;
    nc      = cyc;
    rc      = -1;
    while (k < 300) begin
      @(negedge clk);
      if (iocs && iorw && ioaddr == 2'b00) begin
        rc = cyc;
        break;
      end
      k++;
    end
    @(posedge clk);
    #1;
    rda = 1'b0;
    chk("read_seen", 32'(rc >= 0), 32'd1);
  endtask

  task automatic chk_prog(input int i, input logic [7:0] lo, input logic [7:0] hi);
    chk("prog_lo_addr", 32'(wr_q[i].addr), 32'h2);
    chk("prog_lo_data", 32'(wr_q[i].data), 32'(lo));
    chk("prog_hi_addr", 32'(wr_q[i + 1].addr), 32'h3);
    chk("prog_hi_data", 32'(wr_q[i + 1].data), 32'(hi));
    chk("prog_back_to_back", 32'(wr_q[i + 1].c - wr_q[i].c), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog_vec_t  vecs[4];
    int         rel;
    int         nc;
    int         rc;
    int         stray;
    logic [7:0] b;

    vecs[0] = '{2'b00, 8'h8A, 8'h02};
    vecs[1] = '{2'b01, 8'h44, 8'h01};
    vecs[2] = '{2'b11, 8'h50, 8'h00};
    vecs[3] = '{2'b10, 8'hA1, 8'h00};

    rst_n   = 1'b0;
    br_cfg  = 2'b10;
    rda     = 1'b0;
    tbr     = 1'b0;
    rx_data = 8'h00;
    #2;
    chk("rst_iocs", 32'(iocs), 32'd0);
    chk("rst_iorw", 32'(iorw), 32'd1);
    chk("rst_ioaddr", 32'(ioaddr), 32'h1);
    chk("rst_databus", 32'(databus), 32'hFF);
    chk("rst_last_char", 32'(last_char), 32'h00);

    // Divisor programming for every baud select after a reset release.
    for (int i = 0; i < 4; i++) begin
      rst_n  = 1'b0;
      br_cfg = vecs[i].cfg;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      wr_q.delete();
      rel   = cyc;
      rst_n = 1'b1;
      wait_wr(2, "prog_writes");
      chk_prog(0, vecs[i].lo, vecs[i].hi);
      chk("prog_start_latency", 32'(wr_q[0].c - rel), 32'd2);
      repeat (4) @(negedge clk);
      #1;
      chk("idle_iocs", 32'(iocs), 32'd0);
      chk("idle_no_extra_writes", 32'(wr_q.size()), 32'd2);
    end

    // Basic echo at 19200 with tbr already ready.
    tbr = 1'b1;
    wr_q.delete();
    send(8'h5A, nc, rc);
    chk("rda_to_read_latency", 32'(rc - nc), 32'd1);
    chk("last_char_5a", 32'(last_char), 32'h5A);
    wait_wr(1, "echo_5a_write");
    chk("echo_5a_addr", 32'(wr_q[0].addr), 32'h0);
    chk("echo_5a_data", 32'(wr_q[0].data), 32'h5A);
    chk("echo_5a_delay", 32'(wr_q[0].c - rc), 32'd2);

    // tbr held low: driver parks in WAIT_TBR with the bus released.
    tbr = 1'b0;
    wr_q.delete();
    send(8'h33, nc, rc);
    stray = 0;
    repeat (100) begin
      @(negedge clk);
      if (iocs || databus !== 8'hFF) stray++;
    end
    chk("wait_tbr_quiet", 32'(stray), 32'd0);
    chk("wait_tbr_no_write", 32'(wr_q.size()), 32'd0);
    @(posedge clk);
    #1;
    tbr = 1'b1;
    wait_wr(1, "echo_33_write");
    chk("echo_33_data", 32'(wr_q[0].data), 32'h33);
    repeat (5) @(negedge clk);
    #1;
    chk("echo_33_single", 32'(wr_q.size()), 32'd1);

    // Baud change while waiting for tbr: echo first, then reprogram.
    tbr = 1'b0;
    wr_q.delete();
    send(8'h77, nc, rc);
    @(posedge clk);
    #1;
    br_cfg = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    tbr = 1'b1;
    wait_wr(3, "echo_then_prog");
    chk("echo_77_addr", 32'(wr_q[0].addr), 32'h0);
    chk("echo_77_data", 32'(wr_q[0].data), 32'h77);
    chk_prog(1, 8'h8A, 8'h02);

    // Reset asserted during WR_TX releases the bus without a clock edge.
    tbr = 1'b0;
    wr_q.delete();
    send(8'h44, nc, rc);
    @(posedge clk);
    #1;
    tbr = 1'b1;
    @(posedge clk);
    #2;
    chk("wr_tx_active", 32'(iocs), 32'd1);
    chk("wr_tx_data", 32'(databus), 32'h44);
    rst_n = 1'b0;
    #1;
    chk("async_rst_iocs", 32'(iocs), 32'd0);
    chk("async_rst_iorw", 32'(iorw), 32'd1);
    chk("async_rst_databus", 32'(databus), 32'hFF);
    chk("async_rst_last_char", 32'(last_char), 32'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    wr_q.delete();
    rel   = cyc;
    rst_n = 1'b1;
    wait_wr(2, "reprog_after_rst");
    chk_prog(0, 8'h8A, 8'h02);
    chk("reprog_latency", 32'(wr_q[0].c - rel), 32'd2);

    // Switch to 19200 and echo a burst of random bytes.
    @(posedge clk);
    #1;
    br_cfg = 2'b10;
    wr_q.delete();
    wait_wr(2, "prog_19200");
    chk_prog(0, 8'hA1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_q.delete();
      send(b, nc, rc);
      wait_wr(1, "loop_write");
      chk("loop_addr", 32'(wr_q[0].addr), 32'h0);
      chk("loop_data", 32'(wr_q[0].data), 32'(b));
      chk("loop_last_char", 32'(last_char), 32'(b));
    end
    chk("no_x_on_bus", 32'(x_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
